adbg_xfer_ctrl: RTL

Source-side sequencer for a toggle-handshake clock-domain crossing in the debug interface. Accepts one word per request, holds it stable on a crossing bus, signals the far domain by inverting a toggle line, and waits for the far domain's returned toggle. The returned toggle is detected by a local toggle-synchronizer flop, whose sticky output this block consumes and clears. Exactly one transfer is in flight at a time, with optional timeout supervision.

---
 rtl/adbg_xfer_pkg.sv | 26 ++
 rtl/adbg_xfer_ctrl_timer.sv | 47 ++++
 rtl/adbg_xfer_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/adbg_xfer_pkg.sv
// -----------------------------------------------------------------------------
// adbg_xfer_pkg
// Shared definitions for the debug-interface toggle-handshake transfer
// sequencer: FSM state encoding, default parameter values and a helper that
// sizes the WAIT_ACK supervision timer.
// -----------------------------------------------------------------------------
package adbg_xfer_pkg;

  // Default width of a transferred word.
  localparam int XFER_DW_DEF      = 32;
  // Default number of WAIT_ACK cycles before a timeout is declared.
  localparam int XFER_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_ACK = 2'd2,
    CLEAR    = 2'd3
  } xfer_state_t;

  // Counter width able to hold the value 'cycles' itself.
  function automatic int tmr_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/adbg_xfer_ctrl_timer.sv
// -----------------------------------------------------------------------------
// adbg_xfer_timer
// Clearable saturating up-counter used to supervise the WAIT_ACK phase.
//
// Parameters:
//   LIMIT       saturation value (>= 2)
// Ports:
//   i_clk       clock, posedge
//   i_rstn      synchronous active-low reset, clears the count
//   i_clr       synchronous clear (has priority over increment)
//   i_inc       increment by one, saturating at LIMIT
//   o_expire    high while the count equals LIMIT-1, i.e. the next increment
//               makes the count reach LIMIT
// -----------------------------------------------------------------------------
module adbg_xfer_timer
  import adbg_xfer_pkg::*;
#(
  parameter int LIMIT = XFER_TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expire
);

  localparam int             CW     = tmr_width(LIMIT);
  localparam logic [CW-1:0]  SAT_V  = CW'(LIMIT);
  localparam logic [CW-1:0]  LAST_V = CW'(LIMIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != SAT_V)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Flagged one count early so the owner can act on the same edge at which
  // the count reaches LIMIT.
  assign o_expire = (r_count == LAST_V);

endmodule

// File: rtl/adbg_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// adbg_xfer_ctrl
// Source-side sequencer for a toggle-handshake clock-domain crossing. One word
// is accepted per request, held on o_xfer_data, and announced to the far
// domain by inverting o_xfer_toggle. The far domain's returned toggle arrives
// through a local toggle synchronizer whose sticky output is i_ack_in; this
// block clears that synchronizer via o_ack_clr in LAUNCH (flushing any stale
// acknowledge) and again in CLEAR (consuming the current one).
//
// Optional feature: define ADBG_XFER_TIMEOUT_EN to build the WAIT_ACK timer
// and the sticky timeout flag. Without it WAIT_ACK waits indefinitely,
// o_timeout_err is tied low and i_err_clr is ignored.
//
// Handshake: a word is transferred on any rising clock edge where
// i_req_valid && o_req_ready; i_req_data is sampled on that edge only.
// o_req_ready depends on the state register alone, never on i_req_valid.
//
// Parameters:
//   DW              word width
//   TIMEOUT_CYCLES  WAIT_ACK cycles before timeout (>= 2)
// Ports:
//   i_clk           clock, posedge
//   i_rstn          synchronous active-low reset
//   i_req_valid     requester has a word
//   i_req_data      word to transfer
//   o_req_ready     block can accept (state == IDLE)
//   o_xfer_data     registered word presented to the far domain
//   o_xfer_toggle   registered toggle to the far synchronizer
//   i_ack_in        sticky acknowledge from the local synchronizer
//   o_ack_clr       clear to the local synchronizer (LAUNCH, CLEAR)
//   o_done          one-cycle pulse when a transfer is acknowledged
//   o_busy          state != IDLE
//   o_timeout_err   sticky timeout flag
//   i_err_clr       clears o_timeout_err (a simultaneous set wins)
//   o_dbg_state     current FSM state encoding (xfer_state_t)
// -----------------------------------------------------------------------------
module adbg_xfer_ctrl
  import adbg_xfer_pkg::*;
#(
  parameter int DW             = XFER_DW_DEF,
  parameter int TIMEOUT_CYCLES = XFER_TIMEOUT_DEF
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_req_valid,
  input  logic [DW-1:0] i_req_data,
  output logic          o_req_ready,
  output logic [DW-1:0] o_xfer_data,
  output logic          o_xfer_toggle,
  input  logic          i_ack_in,
  output logic          o_ack_clr,
  output logic          o_done,
  output logic          o_busy,
  output logic          o_timeout_err,
  input  logic          i_err_clr,
  output logic [1:0]    o_dbg_state
);

  xfer_state_t   r_state;
  logic [DW-1:0] r_xfer_data;
  logic          r_toggle;
  logic          r_done;
  logic          w_timeout;

`ifdef ADBG_XFER_TIMEOUT_EN
  logic w_tmr_clr;
  logic w_tmr_inc;
  logic w_tmr_expire;
  logic r_timeout_err;

  // Timer restarts on the LAUNCH -> WAIT_ACK edge and counts every WAIT_ACK
  // cycle that passes without an acknowledge.
  assign w_tmr_clr = (r_state == LAUNCH);
  assign w_tmr_inc = (r_state == WAIT_ACK) && !i_ack_in;

  adbg_xfer_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_clr    (w_tmr_clr),
    .i_inc    (w_tmr_inc),
    .o_expire (w_tmr_expire)
  );

  // An acknowledge in the expiry cycle takes precedence over the timeout.
  assign w_timeout = (r_state == WAIT_ACK) && !i_ack_in && w_tmr_expire;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end else if (i_err_clr) begin
      r_timeout_err <= 1'b0;
    end
  end

  assign o_timeout_err = r_timeout_err;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic w_unused_err_clr;

  assign w_unused_err_clr = i_err_clr;
  assign w_timeout        = 1'b0;
  assign o_timeout_err    = 1'b0;
`endif

  // Sequencer. The word register only loads on acceptance, so the crossing
  // bus is stable for at least the LAUNCH cycle before the toggle flips and
  // for the whole toggle phase after it.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= IDLE;
      r_xfer_data <= '0;
      r_toggle    <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          // i_ack_in is deliberately ignored here; any stale value is
          // flushed by the clear issued in LAUNCH.
          if (i_req_valid) begin
            r_xfer_data <= i_req_data;
            r_state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_toggle <= ~r_toggle;
          r_state  <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (i_ack_in) begin
            r_done  <= 1'b1;
            r_state <= CLEAR;
          end else if (w_timeout) begin
            r_state <= CLEAR;
          end
        end
        CLEAR: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // State-decoded outputs: no combinational path from any input.
  assign o_req_ready   = (r_state == IDLE);
  assign o_busy        = (r_state != IDLE);
  assign o_ack_clr     = (r_state == LAUNCH) || (r_state == CLEAR);
  assign o_xfer_data   = r_xfer_data;
  assign o_xfer_toggle = r_toggle;
  assign o_done        = r_done;
  assign o_dbg_state   = r_state;

endmodule
